// File: rtl/pattern_streamer.sv
// pattern_streamer
//   Test-pattern source for the video DMA path. It generates one of four 24-bit
//   RGB patterns (circle outline, colour bars, checkerboard, gradient) and packs
//   them into a 32-bit AXI4-Stream, 4 pixels per 3 words:
//     w0 = {Pb[7:0], Pa}, w1 = {Pc[15:0], Pb[23:8]}, w2 = {Pd, Pc[23:16]}
//   tuser marks the first word of a frame and tlast the last word of each line.
//
// Ports
//   aclk, areset         clock; asynchronous active-high reset
//   mode[1:0]            0 circle, 1 colour bars, 2 checkerboard, 3 gradient.
//                        Sampled once per frame, on the frame's first word.
//   out_stream_t*        AXI4-Stream master (tdata/tkeep/tlast/tuser/tvalid, tready in)
//
// Optional feature: define PATTERN_STREAMER_SCROLL_EN to add an 8-bit frame
//   counter. Modes 1-3 then use x' = (x + frame_count) mod X_SIZE, so the
//   pattern scrolls left one pixel per frame.

module pattern_streamer #(
    parameter int X_SIZE     = 640,
    parameter int Y_SIZE     = 480,
    parameter int XW         = 10,
    parameter int YW         = 9,
    parameter int RADIUS     = 100,
    parameter int THICKNESS  = 2,
    parameter int CHECK_LOG2 = 5
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [1:0]  mode,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    input  logic        out_stream_tready,
    output logic        out_stream_tvalid,
    output logic        out_stream_tuser
);

    // Signed working width for the circle maths. Doubling it keeps d2 exact.
    localparam int MW = ((XW > YW) ? XW : YW) + 1;
    localparam int DW = 2 * MW;

    localparam logic signed [DW-1:0] CX     = DW'(X_SIZE / 2);
    localparam logic signed [DW-1:0] CY     = DW'(Y_SIZE / 2);
    localparam logic signed [DW-1:0] R_OUT2 = DW'(RADIUS * RADIUS);
    localparam logic signed [DW-1:0] R_IN2  = DW'((RADIUS - THICKNESS) * (RADIUS - THICKNESS));
    localparam logic [XW-1:0]        X_LAST = XW'(X_SIZE - 4);
    localparam logic [YW-1:0]        Y_LAST = YW'(Y_SIZE - 1);
    localparam logic [XW-1:0]        BAR_W  = XW'(X_SIZE / 8);

    // Bar colours. Index 0 is the leftmost bar.
    localparam logic [7:0][23:0] BARS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    // x is the true coordinate, used by the circle.
    // xs is the (possibly scrolled) coordinate, used by the other modes.
    function automatic logic [23:0] f_pix(input logic [1:0]    m,
                                          input logic [XW-1:0] x,
                                          input logic [XW-1:0] xs,
                                          input logic [YW-1:0] y);
        logic signed [DW-1:0] dx;
        logic signed [DW-1:0] dy;
        logic signed [DW-1:0] d2;
        logic [23:0]          p;
        dx = $signed(DW'(x)) - CX;
        dy = $signed(DW'(y)) - CY;
        d2 = dx * dx + dy * dy;
        case (m)
            2'd0:    p = (d2 >= R_IN2 && d2 <= R_OUT2) ? 24'h0000FF : 24'hFFFFFF;
            2'd1:    p = BARS[3'(xs / BAR_W)];
            2'd2:    p = (xs[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
            default: p = {8'(xs), 8'(y), 8'(xs) + 8'(y)};
        endcase
        return p;
    endfunction

    // r_x is the x of the current 4-pixel group (a multiple of 4).
    // r_ph selects which of the group's 3 words is next.
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [1:0]    r_ph;
    logic [1:0]    r_mode;
    logic [31:0]   r_tdata;
    logic          r_tvalid;
    logic          r_tlast;
    logic          r_tuser;

    logic          w_load;
    logic          w_first;
    logic          w_eol;
    logic [1:0]    w_mode;
    logic [XW-1:0] w_xa;
    logic [XW-1:0] w_xb;
    logic [XW-1:0] w_xsa;
    logic [XW-1:0] w_xsb;
    logic [23:0]   w_pa;
    logic [23:0]   w_pb;
    logic [31:0]   w_word;

    // The output register refills whenever it is empty or being drained.
    assign w_load  = !r_tvalid || out_stream_tready;
    assign w_first = (r_x == '0) && (r_y == '0) && (r_ph == 2'd0);
    assign w_eol   = (r_ph == 2'd2) && (r_x == X_LAST);
    // A frame's first word already uses the freshly sampled mode.
    assign w_mode  = w_first ? mode : r_mode;

    // Word phase k covers pixels (k, k+1) of the group.
    assign w_xa = r_x + XW'(r_ph);
    assign w_xb = w_xa + XW'(1);

`ifdef PATTERN_STREAMER_SCROLL_EN
    logic [7:0] r_fc;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_fc <= 8'd0;
        end else if (r_tvalid && out_stream_tready && r_tuser) begin
            r_fc <= r_fc + 8'd1;
        end
    end

    assign w_xsa = XW'((32'(w_xa) + 32'(r_fc)) % 32'(X_SIZE));
    assign w_xsb = XW'((32'(w_xb) + 32'(r_fc)) % 32'(X_SIZE));
`else
    assign w_xsa = w_xa;
    assign w_xsb = w_xb;
`endif

    assign w_pa = f_pix(w_mode, w_xa, w_xsa, r_y);
    assign w_pb = f_pix(w_mode, w_xb, w_xsb, r_y);

    always_comb begin
        w_word = {w_pb[7:0], w_pa};
        case (r_ph)
            2'd0:    w_word = {w_pb[7:0], w_pa};
            2'd1:    w_word = {w_pb[15:0], w_pa[23:8]};
            default: w_word = {w_pb, w_pa[23:16]};
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_ph     <= 2'd0;
            r_mode   <= 2'd0;
            r_tdata  <= 32'd0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_word;
            r_tlast  <= w_eol;
            r_tuser  <= w_first;
            if (w_first) begin
                r_mode <= mode;
            end
            if (r_ph == 2'd2) begin
                r_ph <= 2'd0;
                if (w_eol) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(4);
                end
            end else begin
                r_ph <= r_ph + 2'd1;
            end
        end
    end

    assign out_stream_tdata  = r_tdata;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tlast  = r_tlast;
    assign out_stream_tvalid = r_tvalid;
    assign out_stream_tuser  = r_tuser;

endmodule

// File: tb/tb_pattern_streamer.sv
// Testbench for pattern_streamer. It runs a reduced geometry so that whole
// frames stay short: 160x48 pixels, radius 20, thickness 2, 8-pixel checks.
module tb_pattern_streamer;

    localparam int XS  = 160;
    localparam int YS  = 48;
    localparam int XWP = 8;
    localparam int YWP = 6;
    localparam int RAD = 20;
    localparam int TH  = 2;
    localparam int CL  = 3;
    localparam int WPL = 3 * XS / 4;
    localparam int FW  = WPL * YS;

    logic        aclk   = 1'b0;
    logic        areset = 1'b1;
    logic [1:0]  mode   = 2'd0;
    logic        tready = 1'b0;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic        tuser;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int pos    = 0;
    bit tmo    = 0;

    pattern_streamer #(
        .X_SIZE(XS), .Y_SIZE(YS), .XW(XWP), .YW(YWP),
        .RADIUS(RAD), .THICKNESS(TH), .CHECK_LOG2(CL)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .mode              (mode),
        .out_stream_tdata  (tdata),
        .out_stream_tkeep  (tkeep),
        .out_stream_tlast  (tlast),
        .out_stream_tready (tready),
        .out_stream_tvalid (tvalid),
        .out_stream_tuser  (tuser)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [23:0] ref_pix(int m, int x, int y, int fc);
        logic [23:0] bars [8];
        int xs, dx, dy, d2;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        xs = (x + fc) % XS;
        case (m)
            0: begin
                dx = x - XS / 2;
                dy = y - YS / 2;
                d2 = dx * dx + dy * dy;
                return (d2 >= (RAD - TH) * (RAD - TH) && d2 <= RAD * RAD) ? 24'h0000FF : 24'hFFFFFF;
            end
            1: return bars[xs / (XS / 8)];
            2: return (((xs >> CL) ^ (y >> CL)) & 1) != 0 ? 24'h000000 : 24'hFFFFFF;
            default: return {8'(xs), 8'(y), 8'(xs + y)};
        endcase
    endfunction

    function automatic logic [31:0] ref_word(int m, int y, int w, int fc);
        logic [23:0] p [4];
        int g;
        g = w / 3;
        for (int i = 0; i < 4; i++) p[i] = ref_pix(m, 4 * g + i, y, fc);
        case (w % 3)
            0:       return {p[1][7:0], p[0]};
            1:       return {p[2][15:0], p[1][23:8]};
            default: return {p[3], p[2][23:16]};
        endcase
    endfunction

    task automatic check(input string nm, input bit ok, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- streaming scoreboard ----------------
    int          m_y, m_w, m_frame, m_mode;
    bit          m_fresh    = 1;
    bit          prev_stall = 0;
    logic [31:0] p_d;
    logic        p_l, p_u;

    always @(negedge aclk) begin
        int fc;
        logic [31:0] e;
        if (areset) begin
            m_y = 0; m_w = 0; m_frame = 0; m_fresh = 1; prev_stall = 0;
        end else begin
            if (prev_stall)
                check("hold_stable", tvalid && tdata == p_d && tlast == p_l && tuser == p_u,
                      {3'b0, tvalid, tdata}, {3'b0, 1'b1, p_d});
            if (tvalid && tready) begin
                if (m_fresh) begin
                    m_mode  = int'(mode);
                    m_fresh = 0;
                end
`ifdef PATTERN_STREAMER_SCROLL_EN
                fc = m_frame % 256;
`else
                fc = 0;
`endif
                e = ref_word(m_mode, m_y, m_w, fc);
                check($sformatf("stream f%0d y%0d w%0d", m_frame, m_y, m_w),
                      tdata == e && tlast == (m_w == WPL - 1) && tuser == (m_y == 0 && m_w == 0),
                      {2'b0, tuser, tlast, tdata},
                      {2'b0, m_y == 0 && m_w == 0, m_w == WPL - 1, e});
                m_w++;
                if (m_w == WPL) begin
                    m_w = 0;
                    m_y++;
                    if (m_y == YS) begin
                        m_y = 0;
                        m_frame++;
                        m_mode = int'(mode);
                    end
                end
            end
            prev_stall = tvalid && !tready;
            p_d = tdata; p_l = tlast; p_u = tuser;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic xfer(output logic [31:0] d, output logic l, output logic u);
        bit got;
        got = 0; d = '0; l = 0; u = 0;
        tready = 1'b1;
        for (int n = 0; n < 16 && !got; n++) begin
            @(negedge aclk);
            if (tvalid) begin
                d = tdata; l = tlast; u = tuser; got = 1;
            end
            @(posedge aclk);
            #1;
        end
        if (got) pos++;
        else begin
            tmo = 1;
            check("xfer_timeout", got, 36'd0, 36'd1);
        end
    endtask

    task automatic goto_word(input int t);
        logic [31:0] d;
        logic l, u;
        while (pos < t && !tmo) xfer(d, l, u);
    endtask

    task automatic do_reset(input int m);
        areset = 1'b1;
        mode   = 2'(m);
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        pos    = 0;
        tmo    = 0;
    endtask

    task automatic check_release(input string nm);
        int n;
        n = 0;
        while (!tvalid && n < 4) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check(nm, tvalid, 36'(n), 36'd4);
    endtask

    typedef struct {
        int          m;
        int          line;
        int          word;
        logic [31:0] d;
        bit          l;
        bit          u;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] d, d0;
        logic        l, u;
        int          cur_m;
        bit          pat [6];
        int          words, drops, tu, tl;
        bit          seen, tu_ok;

        tbl[0]  = '{0,  0,   0, 32'hFFFFFFFF, 0, 1};
        tbl[1]  = '{0, 24,  45, 32'hFF0000FF, 0, 0};
        tbl[2]  = '{0, 24,  46, 32'h00FF0000, 0, 0};
        tbl[3]  = '{0, 24,  47, 32'hFFFFFF00, 0, 0};
        tbl[4]  = '{0, 24,  75, 32'hFF0000FF, 0, 0};
        tbl[5]  = '{0, 24, 119, 32'hFFFFFFFF, 1, 0};
        tbl[6]  = '{1,  0,  14, 32'hFFFFFFFF, 0, 0};
        tbl[7]  = '{1,  0,  15, 32'h00FFFF00, 0, 0};
        tbl[8]  = '{1,  0,  16, 32'hFF00FFFF, 0, 0};
        tbl[9]  = '{1,  0,  17, 32'hFFFF00FF, 0, 0};
        tbl[10] = '{1,  0, 119, 32'h00000000, 1, 0};
        tbl[11] = '{2,  0,   6, 32'h00000000, 0, 0};
        tbl[12] = '{2,  8,   0, 32'h00000000, 0, 0};
        tbl[13] = '{2,  8,   6, 32'hFFFFFFFF, 0, 0};
        tbl[14] = '{3,  5,   3, 32'h0A040509, 0, 0};
        tbl[15] = '{3,  5,   4, 32'h050B0505, 0, 0};
        tbl[16] = '{3, 47, 119, 32'h9F2FCE9E, 1, 0};

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", tvalid == 1'b0, 36'(tvalid), 36'd0);
        check("rst_tlast",  tlast  == 1'b0, 36'(tlast),  36'd0);
        check("rst_tuser",  tuser  == 1'b0, 36'(tuser),  36'd0);
        check("rst_tdata",  tdata  == 32'd0, 36'(tdata), 36'd0);
        check("rst_tkeep",  tkeep  == 4'hF, 36'(tkeep),  36'hF);
        areset = 1'b0;
        pos    = 0;
        check_release("first_valid_latency");
        cur_m = 0;

        // Directed table, sorted by mode then position
        for (int i = 0; i < 17; i++) begin
            if (tbl[i].m != cur_m || tbl[i].line * WPL + tbl[i].word < pos) begin
                do_reset(tbl[i].m);
                cur_m = tbl[i].m;
            end
            goto_word(tbl[i].line * WPL + tbl[i].word);
            xfer(d, l, u);
            check($sformatf("table%0d", i), d == tbl[i].d && l == tbl[i].l && u == tbl[i].u,
                  {2'b0, u, l, d}, {2'b0, tbl[i].u, tbl[i].l, tbl[i].d});
        end

        // Backpressure pattern over colour-bar line 0, then a held stall
        do_reset(1);
        pat = '{1, 0, 0, 1, 0, 1};
        for (int c = 0; c < 400; c++) begin
            tready = pat[c % 6];
            @(posedge aclk);
            #1;
        end
        tready = 1'b0;
        @(negedge aclk);
        d0 = tdata;
        repeat (3) @(negedge aclk);
        check("stall_hold", tvalid && tdata == d0, {3'b0, tvalid, tdata}, {3'b0, 1'b1, d0});

        // Random backpressure with mid-frame mode changes
        do_reset(int'($urandom_range(0, 3)));
        for (int c = 0; c < 12000; c++) begin
            tready = ($urandom_range(0, 3) != 0);
            if (c % 1500 == 700) mode = 2'($urandom_range(0, 3));
            @(posedge aclk);
            #1;
        end

        // Frame wrap with continuous ready
        do_reset(3);
        tready = 1'b1;
        words = 0; drops = 0; tu = 0; tl = 0; seen = 0; tu_ok = 1;
        for (int c = 0; c < 2 * FW + 10 && words < 2 * FW; c++) begin
            @(negedge aclk);
            if (tvalid) seen = 1;
            else if (seen) drops++;
            if (tvalid) begin
                if (tuser) begin
                    tu++;
                    if (words != 0 && words != FW) tu_ok = 0;
                end
                if (tlast) tl++;
                words++;
            end
            @(posedge aclk);
            #1;
        end
        check("wrap_words", words == 2 * FW, 36'(words), 36'(2 * FW));
        check("wrap_drops", drops == 0, 36'(drops), 36'd0);
        check("wrap_tuser", tu == 2 && tu_ok, 36'(tu), 36'd2);
        check("wrap_tlast", tl == 2 * YS, 36'(tl), 36'(2 * YS));

        // Mode latching: switch 0 -> 2 during frame 0
        do_reset(0);
        goto_word(10 * WPL);
        mode = 2'd2;
        goto_word(FW);
        xfer(d, l, u);
        check("latch_f1_w0", d == 32'hFFFFFFFF && u, {3'b0, u, d}, {3'b0, 1'b1, 32'hFFFFFFFF});
        goto_word(FW + 6);
        xfer(d, l, u);
        check("latch_f1_w6", d == 32'h00000000, 36'(d), 36'd0);

        // Reset mid-line
        do_reset(1);
        goto_word(7 * WPL + 50);
        @(negedge aclk);
        #2;
        areset = 1'b1;
        #1;
        check("midrst_outputs", !tvalid && tdata == 32'd0 && !tlast && !tuser,
              {1'b0, tvalid, tlast, tuser, tdata}, 36'd0);
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        pos    = 0;
        check_release("midrst_latency");
        xfer(d, l, u);
        check("midrst_first", d == 32'hFFFFFFFF && u, {3'b0, u, d}, {3'b0, 1'b1, 32'hFFFFFFFF});

        // Gradient, frame 3 word 0 (scroll-dependent)
        do_reset(3);
        goto_word(3 * FW);
        xfer(d, l, u);
`ifdef PATTERN_STREAMER_SCROLL_EN
        check("f3_w0", d == 32'h04030003 && u, {3'b0, u, d}, {3'b0, 1'b1, 32'h04030003});
`else
        check("f3_w0", d == 32'h01000000 && u, {3'b0, u, d}, {3'b0, 1'b1, 32'h01000000});
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
